// File: rtl/sao_out_8x8_packer.sv
// Pairs each SAO luma 8x8 block with its chroma 4x4 pair and emits one reference-buffer FIFO word.
// It also keeps the per-picture block count, a sticky coordinate-mismatch flag and an end-of-picture pulse.
module sao_out_8x8_packer #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int COORD_WIDTH     = 9,
  parameter int Y_PIX           = 64,
  parameter int CH_PIX          = 16,
  parameter int PIC_WIDTH_WIDTH = 12,
  parameter int CNT_WIDTH       = 16,
  localparam int YW = PIXEL_WIDTH*Y_PIX,
  localparam int CW = PIXEL_WIDTH*CH_PIX,
  localparam int DW = 2*COORD_WIDTH + YW + 2*CW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       y_valid,
  output logic                       y_ready,
  input  logic [COORD_WIDTH-1:0]     y_xc,
  input  logic [COORD_WIDTH-1:0]     y_yc,
  input  logic [YW-1:0]              y_pixels,
  input  logic                       c_valid,
  output logic                       c_ready,
  input  logic [COORD_WIDTH-1:0]     c_xc,
  input  logic [COORD_WIDTH-1:0]     c_yc,
  input  logic [CW-1:0]              cb_pixels,
  input  logic [CW-1:0]              cr_pixels,
  input  logic [PIC_WIDTH_WIDTH-1:0] pic_width_in,
  input  logic [PIC_WIDTH_WIDTH-1:0] pic_height_in,
  input  logic                       fifo_full_in,
  output logic                       fifo_wr_en_out,
  output logic [DW-1:0]              fifo_data_out,
  output logic [CNT_WIDTH-1:0]       block_count_out,
  output logic                       frame_done_out,
  output logic                       coord_err_out
);

  logic                       y_full, c_full;
  logic [COORD_WIDTH-1:0]     ys_x, ys_y, cs_x, cs_y;
  logic [YW-1:0]              ys_pix;
  logic [CW-1:0]              cs_cb, cs_cr;
  logic                       fire, y_acc, c_acc, last;
  logic [PIC_WIDTH_WIDTH-1:0] last_x, last_y;

  assign fire    = y_full & c_full & ~fifo_full_in;
  assign y_ready = ~y_full | fire;
  assign c_ready = ~c_full | fire;
  assign y_acc   = y_valid & y_ready;
  assign c_acc   = c_valid & c_ready;

  assign fifo_wr_en_out = fire;
  assign fifo_data_out  = {ys_x, ys_y, ys_pix, cs_cb, cs_cr};

  // Last block column/row in 8x8 units; the word always carries luma coordinates.
  assign last_x = (pic_width_in  - PIC_WIDTH_WIDTH'(1)) >> 3;
  assign last_y = (pic_height_in - PIC_WIDTH_WIDTH'(1)) >> 3;
  assign last   = (PIC_WIDTH_WIDTH'(ys_x) == last_x) && (PIC_WIDTH_WIDTH'(ys_y) == last_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_full          <= 1'b0;
      c_full          <= 1'b0;
      block_count_out <= '0;
      frame_done_out  <= 1'b0;
      coord_err_out   <= 1'b0;
    end else begin
      // An accept in the same cycle as a fire refills the slot, giving one block per cycle.
      y_full         <= y_acc | (y_full & ~fire);
      c_full         <= c_acc | (c_full & ~fire);
      frame_done_out <= fire & last;
      if (fire) begin
        block_count_out <= last ? '0 : block_count_out + CNT_WIDTH'(1);
        if ({ys_x, ys_y} != {cs_x, cs_y}) coord_err_out <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (y_acc) begin
      ys_x   <= y_xc;
      ys_y   <= y_yc;
      ys_pix <= y_pixels;
    end
    if (c_acc) begin
      cs_x  <= c_xc;
      cs_y  <= c_yc;
      cs_cb <= cb_pixels;
      cs_cr <= cr_pixels;
    end
  end

endmodule

// File: tb/tb_sao_out_8x8_packer.sv
// Directed bench for sao_out_8x8_packer: pairing latency, streaming a full 416x240 picture,
// backpressure, coordinate mismatch and mid-operation reset.
module tb_sao_out_8x8_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         y_valid, c_valid, fifo_full_in;
  logic         y_ready, c_ready, fifo_wr_en_out, frame_done_out, coord_err_out;
  logic [8:0]   y_xc, y_yc, c_xc, c_yc;
  logic [511:0] y_pixels;
  logic [127:0] cb_pixels, cr_pixels;
  logic [11:0]  pic_width_in, pic_height_in;
  logic [785:0] fifo_data_out;
  logic [15:0]  block_count_out;

  int passed = 0;
  int total  = 0;

  sao_out_8x8_packer dut (
    .clk(clk), .reset(reset),
    .y_valid(y_valid), .y_ready(y_ready), .y_xc(y_xc), .y_yc(y_yc), .y_pixels(y_pixels),
    .c_valid(c_valid), .c_ready(c_ready), .c_xc(c_xc), .c_yc(c_yc),
    .cb_pixels(cb_pixels), .cr_pixels(cr_pixels),
    .pic_width_in(pic_width_in), .pic_height_in(pic_height_in),
    .fifo_full_in(fifo_full_in), .fifo_wr_en_out(fifo_wr_en_out), .fifo_data_out(fifo_data_out),
    .block_count_out(block_count_out), .frame_done_out(frame_done_out), .coord_err_out(coord_err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_y(input logic [7:0] seed);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = seed + 8'(i);
    return r;
  endfunction

  function automatic logic [127:0] mk_c(input logic [7:0] seed);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = seed ^ 8'(i * 3);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_word(input string tag, input int x, input int y, input logic [7:0] seed);
    chk({tag, " xc"}, 512'(fifo_data_out[785:777]), 512'(x));
    chk({tag, " yc"}, 512'(fifo_data_out[776:768]), 512'(y));
    chk({tag, " yy"}, fifo_data_out[767:256], mk_y(seed));
    chk({tag, " cbcr"}, 512'(fifo_data_out[255:0]), 512'({mk_c(seed + 8'h55), mk_c(seed + 8'hAA)}));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input int x, input int y, input logic [7:0] seed);
    y_valid = 1'b1; y_xc = 9'(x); y_yc = 9'(y); y_pixels = mk_y(seed);
  endtask

  task automatic set_c(input int x, input int y, input logic [7:0] seed);
    c_valid = 1'b1; c_xc = 9'(x); c_yc = 9'(y);
    cb_pixels = mk_c(seed + 8'h55); cr_pixels = mk_c(seed + 8'hAA);
  endtask

  initial begin
    reset = 1'b0; y_valid = 1'b0; c_valid = 1'b0; fifo_full_in = 1'b0;
    y_xc = '0; y_yc = '0; c_xc = '0; c_yc = '0;
    y_pixels = '0; cb_pixels = '0; cr_pixels = '0;
    pic_width_in = 12'd416; pic_height_in = 12'd240;

    // Reset state
    #1;
    chk("rst y_ready", 512'(y_ready), 512'(1));
    chk("rst c_ready", 512'(c_ready), 512'(1));
    chk("rst wr_en", 512'(fifo_wr_en_out), 512'(0));
    chk("rst count", 512'(block_count_out), 512'(0));
    chk("rst done", 512'(frame_done_out), 512'(0));
    chk("rst err", 512'(coord_err_out), 512'(0));
    step; step;
    reset = 1'b1;
    step;

    // Single pair: luma (0,0), chroma three cycles later
    set_y(0, 0, 8'd0);
    step;
    y_valid = 1'b0;
    chk("sp wait0", 512'(fifo_wr_en_out), 512'(0));
    chk("sp y_ready", 512'(y_ready), 512'(0));
    step;
    chk("sp wait1", 512'(fifo_wr_en_out), 512'(0));
    step;
    chk("sp wait2", 512'(fifo_wr_en_out), 512'(0));
    set_c(0, 0, 8'd0);
    step;
    c_valid = 1'b0;
    chk("sp wr_en", 512'(fifo_wr_en_out), 512'(1));
    chk_word("sp", 0, 0, 8'd0);
    step;
    chk("sp wr_off", 512'(fifo_wr_en_out), 512'(0));
    chk("sp count", 512'(block_count_out), 512'(1));

    // Stream the rest of the 52x30 picture, both streams valid every cycle
    for (int k = 1; k < 1560; k++) begin
      set_y(k % 52, k / 52, 8'(k));
      set_c(k % 52, k / 52, 8'(k));
      chk("st y_ready", 512'(y_ready), 512'(1));
      chk("st c_ready", 512'(c_ready), 512'(1));
      if (k > 1) begin
        chk("st wr_en", 512'(fifo_wr_en_out), 512'(1));
        chk("st xc", 512'(fifo_data_out[785:777]), 512'((k - 1) % 52));
        chk("st yc", 512'(fifo_data_out[776:768]), 512'((k - 1) / 52));
        chk("st count", 512'(block_count_out), 512'(k - 1));
        chk("st done", 512'(frame_done_out), 512'(0));
      end
      step;
    end
    y_valid = 1'b0; c_valid = 1'b0;
    chk("pic last wr", 512'(fifo_wr_en_out), 512'(1));
    chk_word("pic last", 51, 29, 8'(1559));
    chk("pic pre count", 512'(block_count_out), 512'(1559));
    chk("pic pre done", 512'(frame_done_out), 512'(0));
    step;
    chk("pic wr_off", 512'(fifo_wr_en_out), 512'(0));
    chk("pic count0", 512'(block_count_out), 512'(0));
    chk("pic done", 512'(frame_done_out), 512'(1));
    step;
    chk("pic done off", 512'(frame_done_out), 512'(0));

    // Backpressure: both slots full, FIFO full for 10 cycles
    fifo_full_in = 1'b1;
    set_y(5, 2, 8'h77); set_c(5, 2, 8'h77);
    step;
    for (int i = 0; i < 10; i++) begin
      set_y(9, 9, 8'hEE); set_c(9, 9, 8'hEE);
      chk("bp y_ready", 512'(y_ready), 512'(0));
      chk("bp c_ready", 512'(c_ready), 512'(0));
      chk("bp wr_en", 512'(fifo_wr_en_out), 512'(0));
      step;
    end
    y_valid = 1'b0; c_valid = 1'b0;
    fifo_full_in = 1'b0;
    #1;
    chk("bp wr_en", 512'(fifo_wr_en_out), 512'(1));
    chk_word("bp", 5, 2, 8'h77);
    step;
    chk("bp count", 512'(block_count_out), 512'(1));
    chk("bp wr_off", 512'(fifo_wr_en_out), 512'(0));

    // Coordinate mismatch: luma (3,1) with chroma (4,1)
    set_y(3, 1, 8'h31); set_c(4, 1, 8'h31);
    step;
    y_valid = 1'b0; c_valid = 1'b0;
    chk("mm wr_en", 512'(fifo_wr_en_out), 512'(1));
    chk("mm xc", 512'(fifo_data_out[785:777]), 512'(3));
    chk("mm yc", 512'(fifo_data_out[776:768]), 512'(1));
    chk("mm err pre", 512'(coord_err_out), 512'(0));
    step;
    chk("mm err", 512'(coord_err_out), 512'(1));
    chk("mm count", 512'(block_count_out), 512'(2));
    set_y(6, 1, 8'h61); set_c(6, 1, 8'h61);
    step;
    y_valid = 1'b0; c_valid = 1'b0;
    step;
    chk("mm err sticky", 512'(coord_err_out), 512'(1));
    chk("mm count2", 512'(block_count_out), 512'(3));

    // Reset mid-operation with only the luma slot full
    set_y(7, 1, 8'h71);
    step;
    y_valid = 1'b0;
    chk("mr y_ready pre", 512'(y_ready), 512'(0));
    #3 reset = 1'b0;
    #1;
    chk("mr y_ready", 512'(y_ready), 512'(1));
    chk("mr count", 512'(block_count_out), 512'(0));
    chk("mr err", 512'(coord_err_out), 512'(0));
    #2 reset = 1'b1;
    step;
    set_c(7, 1, 8'h71);
    step;
    c_valid = 1'b0;
    chk("mr no wr0", 512'(fifo_wr_en_out), 512'(0));
    chk("mr c_ready", 512'(c_ready), 512'(0));
    step;
    chk("mr no wr1", 512'(fifo_wr_en_out), 512'(0));
    chk("mr count2", 512'(block_count_out), 512'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
